// File: rtl/serial_logic_unit_pkg.sv
// Shared encodings for the bit-serial OR/XOR logic unit.
package serial_logic_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic OP_OR  = 1'b0;
  localparam logic OP_XOR = 1'b1;

endpackage

// File: rtl/serial_logic_unit_orxor.sv
// Selectable OR/XOR gate cell: s=OP_OR gives a|b, s=OP_XOR gives a^b.
module serial_logic_unit_orxor
  import serial_logic_unit_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic s,
  output logic q
);

  always_comb begin
    q = (s == OP_XOR) ? (a ^ b) : (a | b);
  end

endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial OR/XOR unit: one gate cell processes WIDTH operand bit pairs LSB first.
// Optional registered parity output when SERIAL_LOGIC_PARITY_EN is defined.
module serial_logic_unit
  import serial_logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_xor,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             zero
`ifdef SERIAL_LOGIC_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             op_q;
  logic             bit_out;
  logic             last;
  logic [WIDTH-1:0] res_full;

  serial_logic_unit_orxor u_gate (
    .a (a_sr[0]),
    .b (b_sr[0]),
    .s (op_q),
    .q (bit_out)
  );

  assign last     = (cnt == CW'(WIDTH - 1));
  // Only WIDTH-1 bits are stored; the final bit joins them as q is loaded.
  assign res_full = {bit_out, res_sr};

  assign ready = (state == ST_IDLE);
  assign busy  = (state == ST_SHIFT);
  assign done  = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (last)  state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      op_q   <= OP_OR;
      q      <= '0;
      zero   <= 1'b1;
    end else begin
      if (state == ST_IDLE && start) begin
        a_sr <= a;
        b_sr <= b;
        op_q <= op_xor;
        cnt  <= '0;
      end else if (state == ST_SHIFT) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        res_sr <= (WIDTH-1)'(res_full >> 1);
        cnt    <= cnt + CW'(1);
        if (last) begin
          q    <= res_full;
          zero <= (res_full == '0);
        end
      end
    end
  end

`ifdef SERIAL_LOGIC_PARITY_EN
  logic par_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc <= 1'b0;
      parity  <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        par_acc <= 1'b0;
      end else if (state == ST_SHIFT) begin
        par_acc <= par_acc ^ bit_out;
        if (last) parity <= par_acc ^ bit_out;
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed self-checking bench for serial_logic_unit with hand-computed results.
module tb_serial_logic_unit;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op_xor;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic         zero;
`ifdef SERIAL_LOGIC_PARITY_EN
  logic         parity;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] prev_q = '0;

  serial_logic_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_xor (op_xor),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .q      (q),
    .zero   (zero)
`ifdef SERIAL_LOGIC_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Holds start high until an edge occurs while ready is high.
  task automatic accept();
    logic rdy;
    logic ok;
    ok    = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 8 && !ok; i++) begin
      rdy = ready;
      @(posedge clk);
      #1;
      if (rdy) ok = 1'b1;
    end
    start = 1'b0;
    check("accept", {31'd0, ok}, 32'd1);
  endtask

  // mode 0: plain; 1: start pulsed mid-shift with FF operands; 2: operands toggled every cycle
  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vop,
                       input int mode, input logic [W-1:0] exp_q, input logic exp_zero,
                       input logic exp_par);
    int edges;
    a      = va;
    b      = vb;
    op_xor = vop;
    accept();
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("ready_after_accept", {31'd0, ready}, 32'd0);
    check("q_hold", {24'd0, q}, {24'd0, prev_q});
    edges = 0;
    while (!done && edges < 3 * W) begin
      if (mode == 2) begin
        a = ~a;
        b = b ^ 8'h5A;
      end
      if (mode == 1 && edges == 2) begin
        start  = 1'b1;
        a      = 8'hFF;
        b      = 8'hFF;
        op_xor = ~vop;
      end
      if (mode == 1 && edges == 4) start = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
    check("latency", edges, W);
    check("q", {24'd0, q}, {24'd0, exp_q});
    check("zero", {31'd0, zero}, {31'd0, exp_zero});
    check("busy_in_done", {31'd0, busy}, 32'd0);
    check("ready_in_done", {31'd0, ready}, 32'd0);
`ifdef SERIAL_LOGIC_PARITY_EN
    check("parity", {31'd0, parity}, {31'd0, exp_par});
`else
    if (exp_par === 1'bx) $display("unexpected parity argument");
`endif
    prev_q = exp_q;
  endtask

  initial begin
    logic seen_done;
    rst_n  = 1'b0;
    start  = 1'b0;
    op_xor = 1'b0;
    a      = '0;
    b      = '0;
    #12;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", {24'd0, q}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
`ifdef SERIAL_LOGIC_PARITY_EN
    check("rst_parity", {31'd0, parity}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'hA5, 8'h3C, 1'b0, 0, 8'hBD, 1'b0, 1'b0);
    do_op(8'hA5, 8'h3C, 1'b1, 0, 8'h99, 1'b0, 1'b0);
    do_op(8'h5A, 8'h5A, 1'b1, 0, 8'h00, 1'b1, 1'b0);
    do_op(8'h81, 8'h01, 1'b1, 1, 8'h80, 1'b0, 1'b1);
    do_op(8'h12, 8'h34, 1'b0, 2, 8'h36, 1'b0, 1'b0);
    do_op(8'h07, 8'h00, 1'b0, 0, 8'h07, 1'b0, 1'b1);
    do_op(8'hF0, 8'h0F, 1'b1, 0, 8'hFF, 1'b0, 1'b0);

    // Reset dropped part-way through SHIFT.
    a      = 8'hC3;
    b      = 8'h0C;
    op_xor = 1'b0;
    accept();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_q", {24'd0, q}, 32'd0);
    check("mid_rst_zero", {31'd0, zero}, 32'd1);
    check("mid_rst_ready", {31'd0, ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check("no_done_after_rst", {31'd0, seen_done}, 32'd0);
    check("q_after_rst", {24'd0, q}, 32'd0);
    prev_q = '0;
    do_op(8'h3C, 8'hC3, 1'b1, 0, 8'hFF, 1'b0, 1'b0);
    do_op(8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b1, 1'b0);

    @(posedge clk);
    #1;
    check("idle_after_done", {31'd0, ready}, 32'd1);
    check("done_one_cycle", {31'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_logic_unit.md
Name: serial_logic_unit

Overview:
Bit-serial front end for the selectable OR/XOR gate cell. It latches two WIDTH-bit operands and an op select, then feeds one operand bit pair per clock, LSB first, through a single orxor gate. It shifts the gate output into a result register and signals completion with a start/done handshake. It sits between the register file read ports and the result bus, so a multi-bit logic op costs one gate cell instead of WIDTH cells.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while ready=1
op_xor  input  1  0 = OR, 1 = XOR; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
ready  output  1  high in IDLE; start is accepted only then
busy  output  1  high while bits are being processed (SHIFT)
done  output  1  one-cycle pulse; q/zero are valid from this cycle on
q  output  WIDTH  result register
zero  output  1  high when q == 0, registered with q

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready=1, busy=0, done=0, q=0, zero=1, bit counter=0, operand shift regs=0, latched op=0.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE: ready=1. On a clk edge with start=1:
  - latch a, b, op_xor into shift regs;
  - counter=0;
  - go to SHIFT.
  - q holds its previous value until the new op completes.
- SHIFT: busy=1, ready=0.
  - Each edge: gate output bit = op ? a_sr[0]^b_sr[0] : a_sr[0]|b_sr[0].
  - The bit shifts into the MSB of an internal result shift reg; a_sr and b_sr shift right; counter increments.
  - After WIDTH edges (counter == WIDTH-1 at the edge): copy result reg to q, update zero, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, ready=0; then IDLE.
- Latency: start edge at cycle 0, done high during cycle WIDTH+1, ready again in cycle WIDTH+2.
- start while busy or in DONE: ignored, with no effect on the in-flight op.
- Operand changes after acceptance: no effect (operands are latched).
- Counter is ceil(log2(WIDTH))+1 bits; no wrap within an op.
- Reset asserted mid-operation: immediate return to reset values; the partial result is discarded and no done pulse is issued.
- Only q/zero are registered outputs; ready, busy and done decode the state register directly (glitch-free, no combinational path from inputs).

Optional Feature:
Macro SERIAL_LOGIC_PARITY_EN.
- Defined:
  - adds output parity (1 bit), the XOR of all WIDTH result bits;
  - accumulated serially during SHIFT and cleared on acceptance;
  - registered alongside q/zero at the same edge; reset value 0.
- Undefined: no parity port and no parity accumulator flop; all other behaviour is identical.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_DONE=2'b10;
  - op encodings OP_OR=1'b0, OP_XOR=1'b1.
- Sub-module: one instance of the existing orxor gate cell, with a=a_sr[0], b=b_sr[0], s=latched op, q=serial result bit.
- The controller (FSM, counter, shift regs) stays in this module.

Test Plan:
- Basic OR: WIDTH=8, a=0xA5, b=0x3C, op_xor=0 -> done in cycle 9, q=0xBD, zero=0.
- Basic XOR: a=0xA5, b=0x3C, op_xor=1 -> q=0x99, zero=0. Then a=b=0x5A XOR -> q=0x00, zero=1.
- start pulsed during SHIFT with a=0xFF, b=0xFF -> ignored, in-flight result unchanged. Start asserted in the cycle after done accepts a new op (ready=1) -> back-to-back results correct.
- Operands a/b toggled every cycle after acceptance -> q equals the result of the operands latched at the start edge.
- rst_n dropped in cycle 4 of SHIFT -> q=0, zero=1, ready=1, no done pulse. A new op after release completes correctly.
- With SERIAL_LOGIC_PARITY_EN:
  - a=0x07, b=0x00 OR -> q=0x07, parity=1;
  - a=0xA5, b=0x3C XOR -> q=0x99, parity=0.
